// File: rtl/bus_grant_arbiter.sv
// Round-robin bus grant arbiter feeding the bus control encoder.
// Registered one-hot grant with owner hold, lock and bounded-tenure preemption.
module bus_grant_arbiter #(
    parameter int N        = 16,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         lock,
    output logic [N-1:0] grant,
    output logic         bus_busy,
    output logic         timeout_pulse
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [CNT_W-1:0]   hold_cnt;

    logic [N-1:0]       others;
    logic               all_found;
    logic [IDX_W-1:0]   all_idx;
    logic               oth_found;
    logic [IDX_W-1:0]   oth_idx;

    // First set bit of mask scanning start, start+1, ... wrapping mod N.
    function automatic logic [IDX_W:0] rr_pick(input logic [N-1:0] mask,
                                               input logic [IDX_W-1:0] start);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IDX_W'((32'(start) + i) % N);
            if (!found && mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] k);
        return (k == IDX_W'(N - 1)) ? '0 : k + 1'b1;
    endfunction

    // Round-robin candidates: over all requests, and over requests other than the owner.
    always_comb begin
        others = req;
        others[owner] = 1'b0;
        {all_found, all_idx} = rr_pick(req, ptr);
        {oth_found, oth_idx} = rr_pick(others, ptr);
    end

    // Arbitration FSM with registered grant, tenure counter and preemption pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            owner         <= '0;
            hold_cnt      <= '0;
            grant         <= '0;
            bus_busy      <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (all_found) begin
                        grant    <= N'(1) << all_idx;
                        bus_busy <= 1'b1;
                        owner    <= all_idx;
                        ptr      <= ptr_after(all_idx);
                        hold_cnt <= '0;
                        state    <= OWNED;
                    end else begin
                        grant    <= '0;
                        bus_busy <= 1'b0;
                    end
                end
                OWNED: begin
                    if (!req[owner]) begin
                        // Release takes precedence over lock; hand over without an idle gap.
                        if (oth_found) begin
                            grant    <= N'(1) << oth_idx;
                            bus_busy <= 1'b1;
                            owner    <= oth_idx;
                            ptr      <= ptr_after(oth_idx);
                            hold_cnt <= '0;
                        end else begin
                            grant    <= '0;
                            bus_busy <= 1'b0;
                            hold_cnt <= '0;
                            state    <= IDLE;
                        end
                    end else if (!lock && oth_found &&
                                 hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
                        grant         <= N'(1) << oth_idx;
                        bus_busy      <= 1'b1;
                        owner         <= oth_idx;
                        ptr           <= ptr_after(oth_idx);
                        hold_cnt      <= '0;
                        timeout_pulse <= 1'b1;
                    end else if (hold_cnt != CNT_W'(MAX_HOLD - 1)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant    <= '0;
                    bus_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
